// File: rtl/multicycle_cu_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_cu_pkg
//   Shared definitions for the multi-cycle control unit: FSM state encodings,
//   opcode/funct values, ALU operation codes, PC / write-register / write-data
//   select codes, the instruction-class enum and the decoded-instruction struct
//   produced by multicycle_cu_decode and consumed by multicycle_cu.
// -----------------------------------------------------------------------------
package multicycle_cu_pkg;

    // FSM state encodings (also the value driven on the State debug output)
    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_e;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    // ALU operations
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

    // Next-PC source
    localparam logic [1:0] PC_NEXT    = 2'd0;  // PC+4
    localparam logic [1:0] PC_REL     = 2'd1;  // PC+4 + (imm << 2)
    localparam logic [1:0] PC_ABS     = 2'd2;  // jump target field
    localparam logic [1:0] PC_REG_JMP = 2'd3;  // rs register

    // Register-file write address / data sources
    localparam logic [1:0] WR_FROM_RT     = 2'd0;
    localparam logic [1:0] WR_FROM_RD     = 2'd1;
    localparam logic [1:0] WR_FROM_RA     = 2'd2;
    localparam logic       WDATA_FROM_DB  = 1'b0;
    localparam logic       WDATA_FROM_PC4 = 1'b1;

    typedef enum logic [3:0] {
        C_RTYPE,
        C_IMM,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JUMP,
        C_JAL,
        C_JR,
        C_HALT,
        C_ILLEGAL
    } instr_class_e;

    typedef enum logic [1:0] {
        BR_EQ,
        BR_NE,
        BR_GTZ
    } br_cond_e;

    typedef struct packed {
        instr_class_e cls;
        br_cond_e     br;
        alu_op_e      alu_op;
        logic         alu_src_a;
        logic         alu_src_b;
        logic         ext_sel;
    } dec_t;

    // Branch resolution from the SUB flags: rs-rt for BEQ/BNE, rs-0 for BGTZ.
    function automatic logic branch_taken(input br_cond_e br, input logic zero,
                                          input logic sign);
        logic t;
        case (br)
            BR_EQ:   t = zero;
            BR_NE:   t = !zero;
            BR_GTZ:  t = !zero && !sign;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/multicycle_cu_decode.sv
// -----------------------------------------------------------------------------
// multicycle_cu_decode
//   Purely combinational instruction decode: Opcode/Funct -> instruction class,
//   branch condition and the ALU fields (ALUOp, ALUSrcA, ALUSrcB, ExtSel).
//   Ports:
//     opcode_i  [OP_W-1:0]     opcode from IR
//     funct_i   [FUNCT_W-1:0]  funct from IR
//     dec_o     dec_t          decoded fields
// -----------------------------------------------------------------------------
module multicycle_cu_decode
    import multicycle_cu_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6
) (
    input  logic [OP_W-1:0]    opcode_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output dec_t               dec_o
);

    logic [5:0] op6;
    logic [5:0] fn6;

    assign op6 = 6'(opcode_i);
    assign fn6 = 6'(funct_i);

    always_comb begin
        dec_o.cls       = C_ILLEGAL;
        dec_o.br        = BR_EQ;
        dec_o.alu_op    = ALU_ADD;
        dec_o.alu_src_a = 1'b0;
        dec_o.alu_src_b = 1'b0;
        dec_o.ext_sel   = 1'b0;

        case (op6)
            OP_RTYPE: begin
                dec_o.cls = C_RTYPE;
                case (fn6)
                    FUNCT_ADD: dec_o.alu_op = ALU_ADD;
                    FUNCT_SUB: dec_o.alu_op = ALU_SUB;
                    FUNCT_AND: dec_o.alu_op = ALU_AND;
                    FUNCT_OR:  dec_o.alu_op = ALU_OR;
                    FUNCT_SLT: dec_o.alu_op = ALU_SLT;
                    FUNCT_SLL: begin
                        dec_o.alu_op    = ALU_SLL;
                        dec_o.alu_src_a = 1'b1;  // shift amount comes from shamt
                    end
                    FUNCT_JR:  dec_o.cls = C_JR;
                    default:   dec_o.cls = C_ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                dec_o.cls       = C_IMM;
                dec_o.alu_op    = ALU_ADD;
                dec_o.alu_src_b = 1'b1;
                dec_o.ext_sel   = 1'b1;
            end
            OP_ORI: begin
                // logical immediate is zero-extended
                dec_o.cls       = C_IMM;
                dec_o.alu_op    = ALU_OR;
                dec_o.alu_src_b = 1'b1;
            end
            OP_LW, OP_SW: begin
                dec_o.cls       = (op6 == OP_LW) ? C_LOAD : C_STORE;
                dec_o.alu_op    = ALU_ADD;
                dec_o.alu_src_b = 1'b1;
                dec_o.ext_sel   = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BGTZ: begin
                dec_o.cls     = C_BRANCH;
                dec_o.alu_op  = ALU_SUB;
                dec_o.ext_sel = 1'b1;
                dec_o.br      = (op6 == OP_BEQ) ? BR_EQ :
                                (op6 == OP_BNE) ? BR_NE : BR_GTZ;
            end
            OP_J:    dec_o.cls = C_JUMP;
            OP_JAL:  dec_o.cls = C_JAL;
            OP_HALT: dec_o.cls = C_HALT;
            default: dec_o.cls = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// -----------------------------------------------------------------------------
// multicycle_cu
//   Multi-cycle control unit. An FSM walks each instruction through
//   IF/ID/EXE/MEM/WB and drives the datapath strobes as an unregistered decode
//   of (State, Opcode, Funct, flags). HALT is sticky until reset. RetireCnt
//   counts instructions in the cycle that asserts PCWre (the last state of
//   every instruction).
//   Handshakes: in IF the IR loads (IRWre) in any cycle IReady=1 and the FSM
//   advances on that same edge; in MEM the data strobe stays low every cycle
//   and the FSM advances on the edge where DReady=1.
//   Ports:
//     CLK, Reset (async, active-low)
//     Opcode, Funct            instruction fields from IR
//     Zero, Sign               ALU flags (sampled in EXE)
//     IReady, DReady           memory-ready handshakes
//     PCWre, IRWre, RegWre     enables
//     nRD, nWR                 data-memory strobes (active-low)
//     ALUSrcA, ALUSrcB, DB, WrRegSel, WrDataSel, ExtSel, PCSel, ALUOp  selects
//     State, Halted, RetireCnt status
// -----------------------------------------------------------------------------
module multicycle_cu
    import multicycle_cu_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    Opcode,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic               Zero,
    input  logic               Sign,
    input  logic               IReady,
    input  logic               DReady,
    output logic               PCWre,
    output logic               IRWre,
    output logic               RegWre,
    output logic               nRD,
    output logic               nWR,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic               DB,
    output logic [1:0]         WrRegSel,
    output logic               WrDataSel,
    output logic               ExtSel,
    output logic [1:0]         PCSel,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         State,
    output logic               Halted,
    output logic [CNT_W-1:0]   RetireCnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dec_t             dec;
    logic             taken;

    multicycle_cu_decode #(
        .OP_W    (OP_W),
        .FUNCT_W (FUNCT_W)
    ) u_decode (
        .opcode_i (Opcode),
        .funct_i  (Funct),
        .dec_o    (dec)
    );

    assign taken     = branch_taken(dec.br, Zero, Sign);
    assign State     = state_q;
    assign RetireCnt = cnt_q;

    // An instruction retires exactly when it loads the PC.
    assign cnt_d = PCWre ? cnt_q + CNT_W'(1) : cnt_q;

    // State register and retire counter
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = IReady ? S_ID : S_IF;
            S_ID: begin
                case (dec.cls)
                    C_JUMP, C_JAL, C_JR, C_ILLEGAL: state_d = S_IF;
                    C_HALT:                         state_d = S_HALT;
                    default:                        state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                case (dec.cls)
                    C_BRANCH:        state_d = S_IF;
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (!DReady)              state_d = S_MEM;
                else if (dec.cls == C_LOAD) state_d = S_WB;
                else                      state_d = S_IF;
            end
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;  // 101/110 recover to fetch
        endcase
    end

    // Output decode
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        nRD       = 1'b1;
        nWR       = 1'b1;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        DB        = 1'b0;
        WrRegSel  = WR_FROM_RT;
        WrDataSel = WDATA_FROM_DB;
        ExtSel    = 1'b0;
        PCSel     = PC_NEXT;
        ALUOp     = ALUOP_W'(ALU_ADD);
        Halted    = 1'b0;

        case (state_q)
            S_IF: begin
                // Gated by Reset so no enable is seen while reset is held.
                IRWre = IReady && Reset;
            end
            S_ID: begin
                case (dec.cls)
                    C_JUMP: begin
                        PCWre = 1'b1;
                        PCSel = PC_ABS;
                    end
                    C_JAL: begin
                        PCWre     = 1'b1;
                        PCSel     = PC_ABS;
                        RegWre    = 1'b1;
                        WrRegSel  = WR_FROM_RA;
                        WrDataSel = WDATA_FROM_PC4;
                    end
                    C_JR: begin
                        PCWre = 1'b1;
                        PCSel = PC_REG_JMP;
                    end
                    C_ILLEGAL: PCWre = 1'b1;  // retire as NOP
                    default: ;
                endcase
            end
            S_EXE, S_MEM, S_WB: begin
                // ALU controls are held from EXE through WB: there is no ALU
                // output register, so the result must stay valid until written.
                ALUOp   = ALUOP_W'(dec.alu_op);
                ALUSrcA = dec.alu_src_a;
                ALUSrcB = dec.alu_src_b;
                ExtSel  = dec.ext_sel;
                if (state_q == S_EXE && dec.cls == C_BRANCH) begin
                    PCWre = 1'b1;
                    PCSel = taken ? PC_REL : PC_NEXT;
                end
                if (state_q == S_MEM) begin
                    nRD   = !(dec.cls == C_LOAD);
                    nWR   = !(dec.cls == C_STORE);
                    PCWre = (dec.cls == C_STORE) && DReady;
                end
                if (state_q == S_WB) begin
                    RegWre   = 1'b1;
                    PCWre    = 1'b1;
                    DB       = (dec.cls == C_LOAD);
                    WrRegSel = (dec.cls == C_LOAD || dec.cls == C_IMM) ?
                               WR_FROM_RT : WR_FROM_RD;
                end
            end
            S_HALT: Halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_cu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_cu
//   Directed bench for multicycle_cu (CNT_W=4 so the retire counter wraps).
//   Each clock cycle the driver pushes the full expected control vector for
//   that cycle; the monitor pops and compares it on the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_cu;

    localparam int CNT_W = 4;

    // Encodings used by the design
    localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EXE = 3'b010,
                           ST_MEM = 3'b011, ST_WB = 3'b100, ST_HALT = 3'b111;
    localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_OR = 3'd3,
                           A_SLL = 3'd4, A_SLT = 3'd5;

    typedef struct packed {
        logic [2:0]       state;
        logic             pcwre;
        logic             irwre;
        logic             regwre;
        logic             nrd;
        logic             nwr;
        logic             srca;
        logic             srcb;
        logic             db;
        logic [1:0]       wrsel;
        logic             wdsel;
        logic             ext;
        logic [1:0]       pcsel;
        logic [2:0]       aluop;
        logic             halted;
        logic [CNT_W-1:0] cnt;
    } ctl_t;

    localparam int VW = $bits(ctl_t);

    logic             CLK;
    logic             Reset;
    logic [5:0]       Opcode;
    logic [5:0]       Funct;
    logic             Zero, Sign, IReady, DReady;
    logic             PCWre, IRWre, RegWre, nRD, nWR, ALUSrcA, ALUSrcB, DB;
    logic [1:0]       WrRegSel;
    logic             WrDataSel, ExtSel;
    logic [1:0]       PCSel;
    logic [2:0]       ALUOp;
    logic [2:0]       State;
    logic             Halted;
    logic [CNT_W-1:0] RetireCnt;

    multicycle_cu #(
        .OP_W(6), .FUNCT_W(6), .ALUOP_W(3), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Funct(Funct),
        .Zero(Zero), .Sign(Sign), .IReady(IReady), .DReady(DReady),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .nRD(nRD), .nWR(nWR),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DB(DB), .WrRegSel(WrRegSel),
        .WrDataSel(WrDataSel), .ExtSel(ExtSel), .PCSel(PCSel), .ALUOp(ALUOp),
        .State(State), .Halted(Halted), .RetireCnt(RetireCnt)
    );

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- scoreboard ----------------
    logic [VW-1:0] exp_q[$];
    string         name_q[$];
    int            n_vec  = 0;
    int            n_fail = 0;
    logic          chk_en = 1'b0;
    int            exp_cnt = 0;

    ctl_t  mon_act;
    ctl_t  mon_exp;
    string mon_nm;

    always @(negedge CLK) begin
        if (chk_en) begin
            mon_act.state  = State;
            mon_act.pcwre  = PCWre;
            mon_act.irwre  = IRWre;
            mon_act.regwre = RegWre;
            mon_act.nrd    = nRD;
            mon_act.nwr    = nWR;
            mon_act.srca   = ALUSrcA;
            mon_act.srcb   = ALUSrcB;
            mon_act.db     = DB;
            mon_act.wrsel  = WrRegSel;
            mon_act.wdsel  = WrDataSel;
            mon_act.ext    = ExtSel;
            mon_act.pcsel  = PCSel;
            mon_act.aluop  = ALUOp;
            mon_act.halted = Halted;
            mon_act.cnt    = RetireCnt;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL no_expect: got %h, required a queued vector", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_nm  = name_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got %h, required %h", mon_nm, $time,
                             mon_act, mon_exp);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    function automatic ctl_t base(input logic [2:0] st);
        ctl_t e;
        e       = '0;
        e.state = st;
        e.nrd   = 1'b1;
        e.nwr   = 1'b1;
        e.aluop = A_ADD;
        e.cnt   = exp_cnt[CNT_W-1:0];
        return e;
    endfunction

    task automatic step(input string nm, input ctl_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    task automatic retire();
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    endtask

    task automatic fetch(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input int waitc);
        ctl_t e;
        Opcode = op;
        Funct  = fn;
        IReady = 1'b0;
        repeat (waitc) step({nm, "_ifwait"}, base(ST_IF));
        IReady  = 1'b1;
        e       = base(ST_IF);
        e.irwre = 1'b1;
        step({nm, "_if"}, e);
        IReady = 1'b0;
    endtask

    task automatic alu_ins(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input int ifw, input logic [2:0] aop, input logic sa,
                           input logic sb, input logic ext, input logic [1:0] wrs);
        ctl_t e;
        fetch(nm, op, fn, ifw);
        step({nm, "_id"}, base(ST_ID));
        e       = base(ST_EXE);
        e.aluop = aop;
        e.srca  = sa;
        e.srcb  = sb;
        e.ext   = ext;
        step({nm, "_exe"}, e);
        e.state  = ST_WB;
        e.regwre = 1'b1;
        e.pcwre  = 1'b1;
        e.wrsel  = wrs;
        step({nm, "_wb"}, e);
        retire();
    endtask

    task automatic branch(input string nm, input logic [5:0] op, input logic z,
                          input logic s, input logic tk);
        ctl_t e;
        fetch(nm, op, 6'h00, 0);
        step({nm, "_id"}, base(ST_ID));
        Zero    = z;
        Sign    = s;
        e       = base(ST_EXE);
        e.aluop = A_SUB;
        e.ext   = 1'b1;
        e.pcwre = 1'b1;
        e.pcsel = tk ? 2'd1 : 2'd0;
        step({nm, "_exe"}, e);
        Zero = 1'b0;
        Sign = 1'b0;
        retire();
    endtask

    task automatic jmp(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic [1:0] pcs, input logic link);
        ctl_t e;
        fetch(nm, op, fn, 0);
        e       = base(ST_ID);
        e.pcwre = 1'b1;
        e.pcsel = pcs;
        if (link) begin
            e.regwre = 1'b1;
            e.wrsel  = 2'd2;
            e.wdsel  = 1'b1;
        end
        step({nm, "_id"}, e);
        retire();
    endtask

    task automatic mem_ins(input string nm, input logic load, input int waitc);
        ctl_t e;
        fetch(nm, load ? 6'b100011 : 6'b101011, 6'h00, 0);
        step({nm, "_id"}, base(ST_ID));
        e       = base(ST_EXE);
        e.srcb  = 1'b1;
        e.ext   = 1'b1;
        step({nm, "_exe"}, e);
        e.state = ST_MEM;
        if (load) e.nrd = 1'b0;
        else      e.nwr = 1'b0;
        DReady = 1'b0;
        repeat (waitc) step({nm, "_memwait"}, e);
        DReady = 1'b1;
        if (!load) e.pcwre = 1'b1;
        step({nm, "_mem"}, e);
        DReady = 1'b0;
        if (load) begin
            e.state  = ST_WB;
            e.nrd    = 1'b1;
            e.regwre = 1'b1;
            e.pcwre  = 1'b1;
            e.db     = 1'b1;
            e.wrsel  = 2'd0;
            step({nm, "_wb"}, e);
        end
        retire();
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        ctl_t e;
        Reset  = 1'b0;
        Opcode = 6'h00;
        Funct  = 6'h00;
        Zero   = 1'b0;
        Sign   = 1'b0;
        IReady = 1'b0;
        DReady = 1'b0;
        @(posedge CLK);
        #1;
        chk_en = 1'b1;
        step("reset0", base(ST_IF));
        step("reset1", base(ST_IF));
        Reset = 1'b1;

        // ADD abandoned by reset in WB
        fetch("add_abort", 6'b000000, 6'b100000, 0);
        step("add_abort_id", base(ST_ID));
        e       = base(ST_EXE);
        step("add_abort_exe", e);
        Reset   = 1'b0;   // asynchronous, in the middle of WB
        exp_cnt = 0;
        step("add_abort_rst", base(ST_IF));
        Reset = 1'b1;

        // R-type and immediate ALU instructions
        alu_ins("add",  6'b000000, 6'b100000, 0, A_ADD, 1'b0, 1'b0, 1'b0, 2'd1);
        alu_ins("sub",  6'b000000, 6'b100010, 0, A_SUB, 1'b0, 1'b0, 1'b0, 2'd1);
        alu_ins("slt",  6'b000000, 6'b101010, 0, A_SLT, 1'b0, 1'b0, 1'b0, 2'd1);
        alu_ins("sll",  6'b000000, 6'b000000, 0, A_SLL, 1'b1, 1'b0, 1'b0, 2'd1);
        alu_ins("addi", 6'b001000, 6'b010101, 0, A_ADD, 1'b0, 1'b1, 1'b1, 2'd0);
        alu_ins("ori",  6'b001101, 6'b000000, 2, A_OR,  1'b0, 1'b1, 1'b0, 2'd0);

        // Memory instructions with and without wait states
        mem_ins("lw_w3", 1'b1, 3);
        mem_ins("lw_w0", 1'b1, 0);
        mem_ins("sw_w0", 1'b0, 0);
        mem_ins("sw_w2", 1'b0, 2);

        // Branches: (Zero, Sign) -> taken
        branch("beq_z1",    6'b000100, 1'b1, 1'b0, 1'b1);
        branch("beq_z0",    6'b000100, 1'b0, 1'b0, 1'b0);
        branch("bne_z1",    6'b000101, 1'b1, 1'b0, 1'b0);
        branch("bne_z0",    6'b000101, 1'b0, 1'b0, 1'b1);
        branch("bgtz_pos",  6'b000111, 1'b0, 1'b0, 1'b1);
        branch("bgtz_neg",  6'b000111, 1'b0, 1'b1, 1'b0);
        branch("bgtz_zero", 6'b000111, 1'b1, 1'b0, 1'b0);

        // Jumps
        jmp("jal", 6'b000011, 6'b000000, 2'd2, 1'b1);
        jmp("jr",  6'b000000, 6'b001000, 2'd3, 1'b0);
        jmp("j",   6'b000010, 6'b000000, 2'd2, 1'b0);

        // Undefined opcode retires as a NOP with no register write
        jmp("illegal", 6'b010101, 6'b000000, 2'd0, 1'b0);

        // 16 jumps: the 4-bit counter passes 15 -> 0
        for (int i = 0; i < 16; i++) jmp("j_wrap", 6'b000010, 6'b000000, 2'd2, 1'b0);

        // HALT is sticky and not counted
        fetch("halt", 6'b111111, 6'b000000, 0);
        step("halt_id", base(ST_ID));
        IReady = 1'b1;
        for (int i = 0; i < 11; i++) begin
            e        = base(ST_HALT);
            e.halted = 1'b1;
            step("halt_hold", e);
        end
        IReady  = 1'b0;
        Reset   = 1'b0;
        exp_cnt = 0;
        step("halt_rst", base(ST_IF));
        Reset = 1'b1;

        alu_ins("add_post", 6'b000000, 6'b100000, 0, A_ADD, 1'b0, 1'b0, 1'b0, 2'd1);

        chk_en = 1'b0;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL leftover: got %0d unchecked vectors, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Safety net so the run always ends
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, required end of stimulus");
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
- Multi-cycle successor to the single-cycle control unit.
- An FSM sequences each instruction through IF/ID/EXE/MEM/WB and drives per-state datapath strobes.
- Adds memory-ready handshakes, the JAL/JR instructions, a sticky HALT state and a retired-instruction counter.
- Sits between the instruction register (Opcode/Funct) and the multi-cycle datapath (PC, IR, register file, ALU, data memory).

Parameters:
- OP_W, 6, opcode width.
- FUNCT_W, 6, funct width.
- ALUOP_W, 3, ALUOp width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Opcode  in  OP_W  from IR, held stable from ID onward.
- Funct  in  FUNCT_W  from IR.
- Zero  in  1  ALU zero flag, valid in EXE.
- Sign  in  1  ALU sign flag, valid in EXE.
- IReady  in  1  instruction memory has data.
- DReady  in  1  data memory access complete.
- PCWre  out  1  PC load enable.
- IRWre  out  1  IR load enable.
- RegWre  out  1  register-file write enable.
- nRD  out  1  data-memory read strobe, active-low.
- nWR  out  1  data-memory write strobe, active-low.
- ALUSrcA  out  1  0 = rs data, 1 = shamt.
- ALUSrcB  out  1  0 = rt data, 1 = extended immediate.
- DB  out  1  0 = ALU result, 1 = DM data.
- WrRegSel  out  2  0 = rt, 1 = rd, 2 = $31.
- WrDataSel  out  1  0 = DB, 1 = PC+4 (JAL).
- ExtSel  out  1  0 = zero-extend, 1 = sign-extend.
- PCSel  out  2  0 = PC+4, 1 = relative branch, 2 = absolute jump, 3 = register (JR).
- ALUOp  out  ALUOP_W  ALU operation.
- State  out  3  current FSM state.
- Halted  out  1  high in HALT.
- RetireCnt  out  CNT_W  instructions completed since reset.

Behaviour:
- Reset: asynchronous on Reset=0.
  - State=IF, RetireCnt=0.
  - All enables 0; nRD=nWR=1; selects 0; ALUOp=ADD.
  - Outputs are registered-free decode of (State, Opcode, Funct), so they take these values immediately during reset.
  - Reset mid-instruction abandons it; no write occurs.
- States:
  - IF=000: PCWre=0, IRWre=IReady. Stay while IReady=0; when IReady=1 go to ID.
  - ID=001:
    - J, JAL, JR: PCWre=1 with PCSel=2, 2, 3 respectively, then return to IF.
    - JAL additionally asserts RegWre=1, WrRegSel=2, WrDataSel=1.
    - HALT: go to HALT.
    - Otherwise go to EXE.
  - EXE=010:
    - ALUOp/ALUSrcA/ALUSrcB/ExtSel decoded exactly as the single-cycle CU.
    - BEQ/BNE/BGTZ use SUB and evaluate Zero/Sign this cycle. Branches assert PCWre=1 with PCSel=1 if taken, else 0, then go to IF.
    - LW/SW go to MEM; all others go to WB.
  - MEM=011:
    - LW holds nRD=0; SW holds nWR=0. Stay while DReady=0.
    - On DReady: LW goes to WB; SW asserts PCWre=1, PCSel=0 and goes to IF.
    - Strobe stays asserted every MEM cycle until DReady.
  - WB=100:
    - RegWre=1, PCWre=1, PCSel=0, go to IF.
    - DB=1 for LW; WrRegSel=0 for LW/ADDI/ORI, else 1.
  - HALT=111: all enables 0, Halted=1. Exit only via reset.
- Any undefined opcode in ID is treated as NOP: go to IF with PCWre=1, PCSel=0, no register write.
- PCWre is asserted in exactly one cycle per instruction, the instruction's last state.
- RetireCnt increments in that same cycle, wraps modulo 2^CNT_W, and does not count HALT.
- Undefined State encodings (101, 110) go to IF next cycle.
- Per-instruction cycle counts with zero wait states:
  - J/JAL/JR: 2.
  - Branch: 3.
  - R-type / immediate: 4.
  - SW: 4.
  - LW: 5.

Decomposition:
- Shared `head.v` gains:
  - State encodings S_IF/S_ID/S_EXE/S_MEM/S_WB/S_HALT.
  - OP_JAL, FUNCT_JR.
  - PC_REG_JMP, WR_FROM_RT/RD/RA, WDATA_FROM_DB/PC4.
- Existing opcode/funct/ALU/PC macros are reused.
- One sub-module, cu_decode: combinational Opcode/Funct → instruction class (RTYPE, IMM, LOAD, STORE, BRANCH, JUMP, JAL, JR, HALT, ILLEGAL) plus the ALUOp/src/ext fields.
- The FSM, counter and strobe gating live in multicycle_cu.

Test Plan:
- Reset=0 mid-WB of ADD → State=IF at once, RegWre=0, RetireCnt=0; release and ADD (IReady=1) → IF, ID, EXE, WB; WB shows RegWre=1, WrRegSel=1, ALUOp=ADD; RetireCnt=1.
- LW with DReady low 3 cycles → nRD=0 held 4 MEM cycles, then WB with DB=1, WrRegSel=0; total 8 cycles.
- BEQ with Zero=1 → EXE PCWre=1, PCSel=1; BNE with Zero=1 → PCSel=0; BGTZ with Sign=0, Zero=0 → PCSel=1.
- JAL → ID cycle: PCWre=1, PCSel=2, RegWre=1, WrRegSel=2, WrDataSel=1; JR → PCSel=3, RegWre=0; each takes 2 cycles.
- HALT → State=111, Halted=1; 10 further clocks with IReady=1 leave PCWre=0 and RetireCnt unchanged; Reset=0 → IF.
- CNT_W=4, 16 consecutive J instructions → RetireCnt wraps 15→0; illegal opcode → NOP retire, RegWre never 1.
